// File: rtl/tvip_axi_sample_outstanding_limiter_if.sv
// Handshake-only bundle between the upstream delay stage, the outstanding
// limiter and the downstream slave model. Payloads never pass through here.
interface tvip_axi_sample_outstanding_limiter_if;
  // AW channel
  logic i_awvalid;
  logic o_awready;
  logic o_awvalid;
  logic i_awready;
  // B channel (observed only)
  logic i_bvalid;
  logic i_bready;
  // AR channel
  logic i_arvalid;
  logic o_arready;
  logic o_arvalid;
  logic i_arready;
  // R channel (observed only)
  logic i_rvalid;
  logic i_rready;
  logic i_rlast;

  // Limiter view: consumes upstream/downstream handshakes, drives gated ones.
  modport slave (
    input  i_awvalid, i_awready, i_bvalid, i_bready,
    input  i_arvalid, i_arready, i_rvalid, i_rready, i_rlast,
    output o_awready, o_awvalid, o_arready, o_arvalid
  );

  // Environment view: drives raw handshakes, observes gated ones.
  modport master (
    output i_awvalid, i_awready, i_bvalid, i_bready,
    output i_arvalid, i_arready, i_rvalid, i_rready, i_rlast,
    input  o_awready, o_awvalid, o_arready, o_arvalid
  );
endinterface

// File: rtl/tvip_axi_sample_outstanding_limiter.sv
// Caps outstanding AXI write/read transactions by masking the AW/AR
// valid/ready pair once the registered outstanding count reaches its cap.
// Counts address acceptances against completions (B handshake, R last beat).
module tvip_axi_sample_outstanding_limiter #(
  parameter int MAX_WRITE_OUTSTANDING = 4,
  parameter int MAX_READ_OUTSTANDING  = 4,
  localparam int WCW = $clog2(MAX_WRITE_OUTSTANDING + 1),
  localparam int RCW = $clog2(MAX_READ_OUTSTANDING + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_enable,
  tvip_axi_sample_outstanding_limiter_if.slave bus,
  output logic [WCW-1:0]                      o_write_count,
  output logic [RCW-1:0]                      o_read_count,
  output logic                                o_write_underflow,
  output logic                                o_read_underflow
);

  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WRITE_OUTSTANDING);
  localparam logic [RCW-1:0] RMAX = RCW'(MAX_READ_OUTSTANDING);
  localparam logic [WCW-1:0] WSAT = {WCW{1'b1}};
  localparam logic [RCW-1:0] RSAT = {RCW{1'b1}};

  logic [WCW-1:0] write_count_reg, write_count_next;
  logic [RCW-1:0] read_count_reg,  read_count_next;
  logic           write_underflow_reg, write_underflow_next;
  logic           read_underflow_reg,  read_underflow_next;

  logic aw_block, ar_block;
  logic aw_hs, b_hs, ar_hs, r_done;

  // Gating looks only at the registered counts, so a completion never
  // unblocks the address channel combinationally; it takes effect next cycle.
  always_comb begin
    aw_block      = i_enable & (write_count_reg >= WMAX);
    ar_block      = i_enable & (read_count_reg >= RMAX);
    bus.o_awvalid = bus.i_awvalid & ~aw_block;
    bus.o_awready = bus.i_awready & ~aw_block;
    bus.o_arvalid = bus.i_arvalid & ~ar_block;
    bus.o_arready = bus.i_arready & ~ar_block;
    aw_hs         = bus.o_awvalid & bus.i_awready;
    b_hs          = bus.i_bvalid & bus.i_bready;
    ar_hs         = bus.o_arvalid & bus.i_arready;
    r_done        = bus.i_rvalid & bus.i_rready & bus.i_rlast;
  end

  // Write count: saturating increment on acceptance, decrement on completion,
  // completion at zero is an underflow unless an acceptance arrives with it.
  always_comb begin
    write_count_next     = write_count_reg;
    write_underflow_next = write_underflow_reg;
    unique case ({aw_hs, b_hs})
      2'b10: if (write_count_reg != WSAT) write_count_next = write_count_reg + 1'b1;
      2'b01: begin
        if (write_count_reg == '0) write_underflow_next = 1'b1;
        else                       write_count_next     = write_count_reg - 1'b1;
      end
      2'b11: if (write_count_reg == '0) write_count_next = WCW'(1);
      default: ;
    endcase
  end

  // Read count: same rules, completion is the last R beat only.
  always_comb begin
    read_count_next     = read_count_reg;
    read_underflow_next = read_underflow_reg;
    unique case ({ar_hs, r_done})
      2'b10: if (read_count_reg != RSAT) read_count_next = read_count_reg + 1'b1;
      2'b01: begin
        if (read_count_reg == '0) read_underflow_next = 1'b1;
        else                      read_count_next     = read_count_reg - 1'b1;
      end
      2'b11: if (read_count_reg == '0) read_count_next = RCW'(1);
      default: ;
    endcase
  end

  // Count and sticky flag registers; reset clears them immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      write_count_reg     <= '0;
      read_count_reg      <= '0;
      write_underflow_reg <= 1'b0;
      read_underflow_reg  <= 1'b0;
    end else begin
      write_count_reg     <= write_count_next;
      read_count_reg      <= read_count_next;
      write_underflow_reg <= write_underflow_next;
      read_underflow_reg  <= read_underflow_next;
    end
  end

  // Status outputs straight from the registers.
  always_comb begin
    o_write_count     = write_count_reg;
    o_read_count      = read_count_reg;
    o_write_underflow = write_underflow_reg;
    o_read_underflow  = read_underflow_reg;
  end

endmodule
